// File: rtl/cpu_bus_bridge_pkg.sv
// Shared types and address decode for the CPU bus bridge.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEM,
        IO,
        NULL,
        RESP
    } bus_state_t;

    typedef enum logic [1:0] {
        REG_MEM,
        REG_IO,
        REG_NULL
    } region_t;

    localparam logic [31:0] IO_FAIL_DATA = 32'hFFFF_FFFF;

    // SRAM wins when the address fits in mem_aw bits; the IO page sits at the top of the map.
    function automatic region_t decode_region(input logic [31:0] addr,
                                              input int unsigned mem_aw,
                                              input logic [31:0] io_base);
        region_t r;
        if ((addr >> mem_aw) == 32'd0) begin
            r = REG_MEM;
        end else if (addr >= io_base) begin
            r = REG_IO;
        end else begin
            r = REG_NULL;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// Signal bundle between the core, the bridge and its SRAM / IO targets.
interface cpu_bus_bridge_if #(
    parameter int DW     = 32,
    parameter int MEM_AW = 16
);
    logic              i_req;
    logic              i_we;
    logic [DW-1:0]     i_addr;
    logic [DW-1:0]     i_wdata;
    logic [DW-1:0]     o_rdata;
    logic              o_ready;
    logic              o_busy;

    logic              o_mem_cs;
    logic              o_mem_we;
    logic [MEM_AW-1:0] o_mem_addr;
    logic [DW-1:0]     o_mem_wdata;
    logic [DW-1:0]     i_mem_rdata;

    logic              o_io_sel;
    logic              o_io_we;
    logic [7:0]        o_io_addr;
    logic [DW-1:0]     o_io_wdata;
    logic [DW-1:0]     i_io_rdata;
    logic              i_io_ack;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_io_rdata, i_io_ack,
        output o_rdata, o_ready, o_busy,
               o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata,
               o_io_sel, o_io_we, o_io_addr, o_io_wdata
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_io_rdata, i_io_ack,
        input  o_rdata, o_ready, o_busy,
               o_mem_cs, o_mem_we, o_mem_addr, o_mem_wdata,
               o_io_sel, o_io_we, o_io_addr, o_io_wdata
    );
endinterface

// File: rtl/cpu_bus_bridge_wait_timer.sv
// Loadable 4-bit down-counter; o_done is high while the count sits at zero.
module bus_wait_timer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic       o_done
);
    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_done = (count_q == 4'd0);

endmodule

// File: rtl/cpu_bus_bridge.sv
// Services core bus requests against SRAM (fixed wait), an IO page (ack/timeout) or unmapped space.
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int          DW         = 32,
    parameter int          MEM_AW     = 16,
    parameter int          MEM_WAIT   = 2,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
    parameter int          IO_TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cpu_bus_bridge_if.slave bus
);
    bus_state_t        state_q, state_d;
    logic              armed_q, armed_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [MEM_AW-1:0] addr_q;
    logic              we_q;
    logic [DW-1:0]     wdata_q;

    region_t           region;
    logic              accept;
    logic [3:0]        load_val;
    logic              timer_done;
    logic              mem_phase;
    logic              io_phase;

    assign region = decode_region(bus.i_addr, MEM_AW, IO_BASE);

    // The timer is loaded with (cycles - 1) so done rises on the final wait/timeout cycle.
    bus_wait_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (accept),
        .i_load_val (load_val),
        .o_done     (timer_done)
    );

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        accept   = 1'b0;
        load_val = 4'd0;
        armed_d  = armed_q;

        if (!bus.i_req) begin
            armed_d = 1'b1;
        end else if (state_q == RESP) begin
            armed_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_req && armed_q) begin
                    accept = 1'b1;
                    case (region)
                        REG_MEM: begin
                            state_d  = MEM;
                            load_val = 4'(MEM_WAIT);
                        end
                        REG_IO: begin
                            state_d  = IO;
                            load_val = 4'(IO_TIMEOUT - 1);
                        end
                        default: state_d = NULL;
                    endcase
                end
            end
            MEM: begin
                if (timer_done) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : bus.i_mem_rdata;
                end
            end
            IO: begin
                // Ack takes precedence when it coincides with the timeout cycle.
                if (bus.i_io_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : bus.i_io_rdata;
                end else if (timer_done) begin
                    state_d = RESP;
                    rdata_d = DW'(IO_FAIL_DATA);
                end
            end
            NULL: begin
                state_d = RESP;
                rdata_d = '0;
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= bus.i_addr[MEM_AW-1:0];
                we_q    <= bus.i_we;
                wdata_q <= bus.i_wdata;
            end
        end
    end

    assign mem_phase = (state_q == MEM);
    assign io_phase  = (state_q == IO);

    assign bus.o_ready     = (state_q == RESP);
    assign bus.o_rdata     = rdata_q;
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_mem_cs    = mem_phase;
    assign bus.o_mem_we    = mem_phase & we_q;
    assign bus.o_mem_addr  = mem_phase ? addr_q : '0;
    assign bus.o_mem_wdata = mem_phase ? wdata_q : '0;
    assign bus.o_io_sel    = io_phase;
    assign bus.o_io_we     = io_phase & we_q;
    assign bus.o_io_addr   = io_phase ? addr_q[7:0] : 8'd0;
    assign bus.o_io_wdata  = io_phase ? wdata_q : '0;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Self-checking bench: directed vector table, reset-abort sequence, randomized accesses vs. a reference model.
module tb_cpu_bus_bridge;

    localparam int MEM_WAIT   = 2;
    localparam int IO_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_bus_bridge_if #(.DW(32), .MEM_AW(16)) bus ();

    cpu_bus_bridge #(
        .DW         (32),
        .MEM_AW     (16),
        .MEM_WAIT   (MEM_WAIT),
        .IO_BASE    (32'hFFFF_FF00),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic [31:0] ird;
        int          ack_at;   // sel cycle on which the IO target acks; 0 = never
        int          hold;     // cycles i_req stays high after the accept cycle
        int          lat;
        int          cs;
        int          sel;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          lat;
        int          cs;
        int          sel;
        int          readies;
        logic [31:0] rdata;
        logic [31:0] rdata_after;
        logic        pins_ok;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected outcome derived from the address map and the wait/ack/timeout rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   k;
        if (v.addr < 32'h0001_0000) begin
            r.lat = MEM_WAIT + 2;  r.cs = MEM_WAIT + 1;  r.sel = 0;
            r.rdata = v.we ? 32'd0 : v.mrd;
        end else if (v.addr >= 32'hFFFF_FF00) begin
            r.cs = 0;
            if (v.ack_at >= 1 && v.ack_at <= IO_TIMEOUT) begin
                k = v.ack_at;
                r.rdata = v.we ? 32'd0 : v.ird;
            end else begin
                k = IO_TIMEOUT;
                r.rdata = 32'hFFFF_FFFF;
            end
            r.sel = k;  r.lat = k + 1;
        end else begin
            r.lat = 2;  r.cs = 0;  r.sel = 0;  r.rdata = 32'd0;
        end
        return r;
    endfunction

    // Presents one request in the current cycle (the accept cycle) and watches the bus cycle by cycle.
    task automatic run_access(input vec_t v, output obs_t o);
        o.lat = -1;  o.cs = 0;  o.sel = 0;  o.readies = 0;
        o.rdata = 32'd0;  o.rdata_after = 32'hDEAD_0000;  o.pins_ok = 1'b1;
        bus.i_req = 1'b1;  bus.i_we = v.we;  bus.i_addr = v.addr;  bus.i_wdata = v.wdata;
        bus.i_mem_rdata = v.mrd;  bus.i_io_rdata = v.ird;  bus.i_io_ack = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            bus.i_addr  = $urandom;
            bus.i_wdata = $urandom;
            bus.i_we    = 1'($urandom_range(0, 1));
            if (n > v.hold) bus.i_req = 1'b0;
            bus.i_io_ack = 1'b0;
            if (bus.o_mem_cs === 1'b1) begin
                o.cs++;
                if (bus.o_mem_addr !== v.addr[15:0] || bus.o_mem_we !== v.we ||
                    bus.o_mem_wdata !== v.wdata) o.pins_ok = 1'b0;
            end
            if (bus.o_io_sel === 1'b1) begin
                o.sel++;
                if (bus.o_io_addr !== v.addr[7:0] || bus.o_io_we !== v.we ||
                    bus.o_io_wdata !== v.wdata) o.pins_ok = 1'b0;
                if (o.sel == v.ack_at) bus.i_io_ack = 1'b1;
            end
            if (o.lat >= 0 && n == o.lat + 1) o.rdata_after = bus.o_rdata;
            if (bus.o_ready === 1'b1) begin
                o.readies++;
                if (o.lat < 0) begin
                    o.lat   = n;
                    o.rdata = bus.o_rdata;
                end
            end
            if (o.lat >= 0 && n > o.lat + 2 && n > v.hold + 2) break;
        end
        bus.i_req = 1'b0;
        bus.i_io_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_obs(input string tag, input vec_t e, input obs_t o);
        check({tag, " latency"},    32'(o.lat),     32'(e.lat));
        check({tag, " rdata"},      o.rdata,        e.rdata);
        check({tag, " cs_cycles"},  32'(o.cs),      32'(e.cs));
        check({tag, " sel_cycles"}, 32'(o.sel),     32'(e.sel));
        check({tag, " ready_cnt"},  32'(o.readies), 32'd1);
        check({tag, " pins"},       32'(o.pins_ok), 32'd1);
        check({tag, " rdata_clr"},  o.rdata_after,  32'd0);
        $display("access %s addr=%h we=%0d lat=%0d rdata=%h cs=%0d sel=%0d",
                 tag, e.addr, e.we, o.lat, o.rdata, o.cs, o.sel);
    endtask

    vec_t vecs[10];
    vec_t v;
    obs_t o;
    int   ready_seen;

    initial begin
        //          addr          we    wdata         mrd           ird           ack hold lat cs sel rdata
        vecs[0] = '{32'h0000_1234, 1'b0, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 0,  4, 3, 0,  32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0010, 1'b1, 32'h55,       32'h1111_2222, 32'h0,        0, 10, 4, 3, 0,  32'h0};
        vecs[2] = '{32'hFFFF_FF04, 1'b0, 32'h0,        32'h0,        32'h42,       5, 0,  6, 0, 5,  32'h42};
        vecs[3] = '{32'hFFFF_FF10, 1'b1, 32'hABCD,     32'h0,        32'h77,       0, 0,  16, 0, 15, 32'hFFFF_FFFF};
        vecs[4] = '{32'h0002_0000, 1'b0, 32'h0,        32'h3333_3333, 32'h4444_4444, 0, 0,  2, 0, 0,  32'h0};
        vecs[5] = '{32'hFFFF_FFFF, 1'b0, 32'h0,        32'h0,        32'h1357,     15, 0, 16, 0, 15, 32'h1357};
        vecs[6] = '{32'hFFFF_FF00, 1'b0, 32'h0,        32'h0,        32'hA5A5,     1, 3,  2, 0, 1,  32'hA5A5};
        vecs[7] = '{32'h0000_FFFF, 1'b0, 32'h0,        32'h0BAD_F00D, 32'h0,        0, 6,  4, 3, 0,  32'h0BAD_F00D};
        vecs[8] = '{32'hFFFF_FEFF, 1'b1, 32'h99,       32'h5555_5555, 32'h6666_6666, 0, 0,  2, 0, 0,  32'h0};
        vecs[9] = '{32'hFFFF_FF80, 1'b1, 32'h1234,     32'h0,        32'hBEEF,     3, 0,  4, 0, 3,  32'h0};

        rst = 1'b1;
        bus.i_req = 1'b0;  bus.i_we = 1'b0;  bus.i_addr = 32'd0;  bus.i_wdata = 32'd0;
        bus.i_mem_rdata = 32'd0;  bus.i_io_rdata = 32'd0;  bus.i_io_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctl", {31'd0, bus.o_ready | bus.o_busy | bus.o_mem_cs | bus.o_io_sel}, 32'd0);
        check("reset rdata", bus.o_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i], o);
            check_obs($sformatf("vec%0d", i), vecs[i], o);
        end

        // Reset during the second MEM wait cycle abandons the access.
        bus.i_req = 1'b1;  bus.i_we = 1'b0;  bus.i_addr = 32'h0000_0100;
        bus.i_mem_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort ctl", {26'd0, bus.o_ready, bus.o_busy, bus.o_mem_cs, bus.o_mem_we,
                                bus.o_io_sel, bus.o_io_we}, 32'd0);
        check("rst_abort data", bus.o_rdata | {16'd0, bus.o_mem_addr} | {24'd0, bus.o_io_addr}, 32'd0);
        ready_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) ready_seen++;
        end
        check("rst_abort no_ready", 32'(ready_seen), 32'd0);
        v = '{32'h0000_0200, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0, 0, 32'h0};
        v = model(v);
        run_access(v, o);
        check_obs("after_rst", v, o);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       v.addr = 32'($urandom_range(0, 32'h0000_FFFF));
                1:       v.addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: v.addr = 32'h0001_0000 + ($urandom % 32'hFFFE_FF00);
            endcase
            v.we     = 1'($urandom_range(0, 1));
            v.wdata  = $urandom;
            v.mrd    = $urandom;
            v.ird    = $urandom;
            v.ack_at = $urandom_range(0, 17);
            v.hold   = $urandom_range(0, 6);
            v = model(v);
            run_access(v, o);
            check_obs($sformatf("rnd%0d", i), v, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
